dcache_sram_arbiter: RTL and testbench
======================================

DCACHE_SRAM_ARBITER -- requirements
Module: dcache_sram_arbiter

Interface
REQ-001 SHALL have parameter NR_PORTS, default 4, number of requesting masters (2..8).
REQ-002 SHALL have parameter NR_WAYS, default 8, number of set-associative ways (1..16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, index-plus-offset width.
REQ-004 SHALL have parameter TAG_WIDTH, default 44, tag width.
REQ-005 SHALL have parameter LINE_WIDTH, default 128, data line width; byte enable width LINE_WIDTH/8.
REQ-006 SHALL have parameter ARB_MODE, default 1, arbitration mode: 0 is fixed priority with port 0 highest, 1 is round-robin.
REQ-007 SHALL have port clk_i, input, 1, clock; single clock, all state on rising edge.
REQ-008 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-009 SHALL have port req_i, input, NR_PORTS x NR_WAYS, per-port way-select request.
REQ-010 SHALL have port lock_i, input, NR_PORTS, keeps the current grant on the next cycle.
REQ-011 SHALL have port addr_i, input, NR_PORTS x ADDR_WIDTH, set address.
REQ-012 SHALL have port tag_i, input, NR_PORTS x TAG_WIDTH, compare tag, valid one cycle after grant.
REQ-013 SHALL have the following write-path inputs:
- we_i, input, NR_PORTS, write enable.
- wdata_i, input, NR_PORTS x (TAG_WIDTH+LINE_WIDTH+2), line: tag, data, valid, dirty.
- be_i, input, NR_PORTS x (LINE_WIDTH/8+NR_WAYS), data byte enables and per-way valid/dirty enables.
REQ-014 SHALL have port gnt_o, input-side response, output, NR_PORTS, one-hot grant.
REQ-015 SHALL have port rvalid_o, output, NR_PORTS, read-data-valid for the port granted one cycle earlier.
REQ-016 SHALL have the following read-response outputs:
- rdata_o, output, NR_WAYS lines, registered-SRAM read data routed to all ports.
- hit_way_o, output, NR_WAYS, one-hot-or-zero hit vector.
- multihit_o, output, 1, more than one way hit.
REQ-017 SHALL have the following SRAM-side ports:
- req_o, output, NR_WAYS.
- addr_o, output, ADDR_WIDTH.
- we_o, output, 1.
- wdata_o, output, line.
- be_o, output, enables.
- rdata_i, input, NR_WAYS lines, valid one cycle after req_o.

Function
REQ-018 SHALL treat port p as requesting when |req_i[p] is true.
REQ-019 SHALL grant at most one port per cycle, combinationally in the same cycle; gnt_o SHALL never assert for a non-requesting port.
REQ-020 SHALL, in ARB_MODE 0, grant the lowest-index requesting port.
REQ-021 SHALL, in ARB_MODE 1, grant the first requesting port at or after the priority pointer, wrapping from NR_PORTS-1 to 0.
REQ-022 SHALL, in ARB_MODE 1, set the pointer to (winner+1) mod NR_PORTS on each grant; no grant leaves the pointer unchanged.
REQ-023 SHALL, when a port was granted with lock_i high and it still requests, grant it again regardless of mode, without updating the pointer.
REQ-024 SHALL clear the lock when the locked port drops its request or deasserts lock_i.
REQ-025 SHALL drive the winner's req_i/addr_i/we_i/wdata_i/be_i onto the SRAM side in the grant cycle; with no grant, req_o and we_o SHALL be 0.
REQ-026 SHALL register the winner id and a read flag (granted and !we_i).
REQ-027 SHALL, one cycle after a read grant, assert rvalid_o[id_q] for exactly one cycle.
REQ-028 SHALL compute hit_way_o[w] = rdata_i[w].valid and rdata_i[w].tag == tag_i[id_q], gated by the registered read flag; hit_way_o SHALL be 0 otherwise.
REQ-029 SHALL assert multihit_o combinationally in the rvalid cycle when popcount(hit_way_o) > 1.
REQ-030 SHALL pass rdata_o = rdata_i unregistered.
REQ-031 SHALL sustain back-to-back grants every cycle: 1-cycle grant-to-rvalid latency, throughput 1 access/cycle.
REQ-032 SHALL, on a write grant, produce no rvalid_o and no hit_way_o in the following cycle.

Reset
REQ-033 SHALL, while rst_i is high at a clock edge, reset the pointer to 0, the lock to none, id_q to 0 and the read flag to 0.
REQ-034 SHALL hold rvalid_o, hit_way_o and multihit_o at 0 in the cycle after reset.
REQ-035 SHALL, when reset occurs mid-access, drop the pending read with no rvalid_o.

Verification
REQ-036 SHALL cover fixed priority: ARB_MODE 0, ports 1 and 3 request -> gnt_o=0010; next cycle rvalid_o=0010.
REQ-037 SHALL cover round-robin: ARB_MODE 1, all 4 ports request continuously -> grant order 0,1,2,3,0, one per cycle.
REQ-038 SHALL cover lock: port 2 requests with lock_i[2]=1 for 3 cycles while port 0 also requests -> gnt_o=0100 for 3 cycles, then port 0 granted.
REQ-039 SHALL cover hit and multihit:
- Read with way 5 valid and tag 0xABC, tag_i=0xABC -> hit_way_o=0x20, multihit_o=0.
- Ways 1 and 5 matching -> multihit_o=1.
REQ-040 SHALL cover write followed by read: port 0 write then read to the same index -> cycle 1 no rvalid; cycle 2 rvalid_o[0]=1, hit on the written way.
REQ-041 SHALL cover reset mid-read: rst_i high in the cycle after a read grant -> rvalid_o=0, pointer=0.

Source files
------------

// File: rtl/dcache_sram_arbiter.sv
// dcache_sram_arbiter: grants one of NR_PORTS masters onto the way SRAMs and checks tags on the registered read data
module dcache_sram_arbiter #(
  parameter int NR_PORTS   = 4,
  parameter int NR_WAYS    = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 44,
  parameter int LINE_WIDTH = 128,
  parameter int ARB_MODE   = 1,
  localparam int LW = TAG_WIDTH + LINE_WIDTH + 2,
  localparam int BW = LINE_WIDTH / 8 + NR_WAYS,
  localparam int IW = $clog2(NR_PORTS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NR_PORTS-1:0][NR_WAYS-1:0]    req_i,
  input  logic [NR_PORTS-1:0]                 lock_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]  tag_i,
  input  logic [NR_PORTS-1:0]                 we_i,
  input  logic [NR_PORTS-1:0][LW-1:0]         wdata_i,
  input  logic [NR_PORTS-1:0][BW-1:0]         be_i,
  output logic [NR_PORTS-1:0]                 gnt_o,
  output logic [NR_PORTS-1:0]                 rvalid_o,
  output logic [NR_WAYS-1:0][LW-1:0]          rdata_o,
  output logic [NR_WAYS-1:0]                  hit_way_o,
  output logic                                multihit_o,
  output logic [NR_WAYS-1:0]                  req_o,
  output logic [ADDR_WIDTH-1:0]               addr_o,
  output logic                                we_o,
  output logic [LW-1:0]                       wdata_o,
  output logic [BW-1:0]                       be_o,
  input  logic [NR_WAYS-1:0][LW-1:0]          rdata_i
);
  logic [IW-1:0]       r_ptr, r_lock_id, r_id;
  logic                r_lock, r_rd;
  logic [NR_PORTS-1:0] w_reqv;
  logic [IW-1:0]       w_win, w_ord;
  logic                w_any, w_lock_hit;
  logic [NR_WAYS-1:0]  w_hit;

  always_comb
    for (int p = 0; p < NR_PORTS; p++) w_reqv[p] = |req_i[p];

  assign w_lock_hit = r_lock & w_reqv[r_lock_id];

  // scan from the lowest priority upwards so the highest-priority requester is written last
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_ord = '0;
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      w_ord = IW'(((ARB_MODE != 0) ? int'(r_ptr) + i : i) % NR_PORTS);
      if (w_reqv[w_ord]) begin
        w_any = 1'b1;
        w_win = w_ord;
      end
    end
    if (w_lock_hit) begin
      w_any = 1'b1;
      w_win = r_lock_id;
    end
  end

  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_id      <= '0;
      r_rd      <= 1'b0;
    end else begin
      r_rd   <= w_any & ~we_i[w_win];
      r_lock <= w_any & lock_i[w_win];
      if (w_any) begin
        r_id      <= w_win;
        r_lock_id <= w_win;
      end
      if (w_any & ~w_lock_hit) r_ptr <= (w_win == IW'(NR_PORTS - 1)) ? '0 : w_win + 1'b1;
    end

  assign gnt_o   = w_any ? NR_PORTS'(1) << w_win : '0;
  assign req_o   = w_any ? req_i[w_win] : '0;
  assign we_o    = w_any & we_i[w_win];
  assign addr_o  = addr_i[w_win];
  assign wdata_o = wdata_i[w_win];
  assign be_o    = be_i[w_win];

  // a reset landing in the response cycle kills the pending read
  always_comb
    for (int w = 0; w < NR_WAYS; w++)
      w_hit[w] = r_rd & ~rst_i & rdata_i[w][1] & (rdata_i[w][LW-1 -: TAG_WIDTH] == tag_i[r_id]);

  assign rvalid_o   = (r_rd & ~rst_i) ? NR_PORTS'(1) << r_id : '0;
  assign hit_way_o  = w_hit;
  assign multihit_o = |(w_hit & (w_hit - NR_WAYS'(1)));
  assign rdata_o    = rdata_i;
endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// tb_dcache_sram_arbiter: fixed-priority and round-robin instances checked against a queue-fed reference model
module tb_dcache_sram_arbiter;
  localparam int NP = 4, NW = 8, AW = 12, TW = 44, LW = 174, BW = 24;
  logic clk = 1'b0;
  logic rst_i;
  logic [NP-1:0][NW-1:0] req_i;
  logic [NP-1:0] lock_i, we_i;
  logic [NP-1:0][AW-1:0] addr_i;
  logic [NP-1:0][TW-1:0] tag_i;
  logic [NP-1:0][LW-1:0] wdata_i;
  logic [NP-1:0][BW-1:0] be_i;
  logic [NW-1:0][LW-1:0] rdata_i;
  logic [1:0][NP-1:0] gnt, rvalid;
  logic [1:0][NW-1:0][LW-1:0] rdata_o;
  logic [1:0][NW-1:0] hit, sreq;
  logic [1:0] mh, swe;
  logic [1:0][AW-1:0] saddr;
  logic [1:0][LW-1:0] swd;
  logic [1:0][BW-1:0] sbe;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    dcache_sram_arbiter #(.ARB_MODE(m)) u_dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i),
      .tag_i(tag_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt[m]),
      .rvalid_o(rvalid[m]), .rdata_o(rdata_o[m]), .hit_way_o(hit[m]), .multihit_o(mh[m]),
      .req_o(sreq[m]), .addr_o(saddr[m]), .we_o(swe[m]), .wdata_o(swd[m]), .be_o(sbe[m]),
      .rdata_i(rdata_i));
  end

  typedef struct {
    logic chk, sw;
    logic [1:0][NP-1:0] g, rv;
    logic [1:0][NW-1:0] h;
    logic [1:0] mh;
    logic [NW-1:0] sreq;
    logic swe;
    logic [AW-1:0] saddr;
    logic [LW-1:0] swd;
    logic [BW-1:0] sbe;
    logic [LW-1:0] rd0;
  } exp_t;
  exp_t q[$];
  int vecs = 0, miss = 0;

  int ptr[2] = '{0, 0}, lockp[2] = '{-1, -1}, pid[2] = '{0, 0};
  bit prd[2] = '{0, 0};

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    vecs++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  // reference: priority order is a rotating list starting at ptr (mode 1) or at port 0 (mode 0)
  task automatic eval(input int m, output logic [NP-1:0] g, output logic [NP-1:0] rv,
                      output logic [NW-1:0] h, output int win, output bit lk);
    win = -1;
    lk  = 0;
    if (lockp[m] >= 0 && req_i[lockp[m]] != 0) begin
      win = lockp[m];
      lk  = 1;
    end else
      for (int i = 0; i < NP && win < 0; i++) begin
        int k;
        k = m != 0 ? (ptr[m] + i) % NP : i;
        if (req_i[k] != 0) win = k;
      end
    g  = win >= 0 ? NP'(1 << win) : '0;
    rv = (prd[m] && !rst_i) ? NP'(1 << pid[m]) : '0;
    for (int w = 0; w < NW; w++)
      h[w] = prd[m] && !rst_i && rdata_i[w][1] && rdata_i[w][LW-1 -: TW] == tag_i[pid[m]];
  endtask

  task automatic update(input int m, input int win, input bit lk);
    if (rst_i) begin
      ptr[m] = 0; lockp[m] = -1; pid[m] = 0; prd[m] = 0;
    end else begin
      prd[m] = win >= 0 && !we_i[win];
      if (win >= 0) pid[m] = win;
      lockp[m] = (win >= 0 && lock_i[win]) ? win : -1;
      if (win >= 0 && !lk) ptr[m] = (win + 1) % NP;
    end
  endtask

  task automatic tick();
    exp_t e;
    int win[2];
    bit lk[2];
    int w1;
    for (int m = 0; m < 2; m++) begin
      eval(m, e.g[m], e.rv[m], e.h[m], win[m], lk[m]);
      e.mh[m] = $countones(e.h[m]) > 1;
    end
    w1 = win[1] < 0 ? 0 : win[1];
    e.chk   = !rst_i;
    e.sw    = win[1] >= 0;
    e.sreq  = e.sw ? req_i[w1] : '0;
    e.swe   = e.sw && we_i[w1];
    e.saddr = addr_i[w1];
    e.swd   = wdata_i[w1];
    e.sbe   = be_i[w1];
    e.rd0   = rdata_i[0];
    q.push_back(e);
    for (int m = 0; m < 2; m++) update(m, win[m], lk[m]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_i = '0; lock_i = '0; we_i = '0; rst_i = 1'b0;
  endtask

  function automatic logic [LW-1:0] line(input logic [TW-1:0] t, input bit v);
    return {t, 128'($urandom), v, 1'b0};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int m = 0; m < 2; m++) begin
          if (e.chk) chk($sformatf("gnt[m%0d]", m), 256'(gnt[m]), 256'(e.g[m]));
          chk($sformatf("rvalid[m%0d]", m), 256'(rvalid[m]), 256'(e.rv[m]));
          chk($sformatf("hit_way[m%0d]", m), 256'(hit[m]), 256'(e.h[m]));
          chk($sformatf("multihit[m%0d]", m), 256'(mh[m]), 256'(e.mh[m]));
        end
        chk("rdata_pass", 256'(rdata_o[1][0]), 256'(e.rd0));
        if (e.chk) begin
          chk("sram_req", 256'(sreq[1]), 256'(e.sreq));
          chk("sram_we", 256'(swe[1]), 256'(e.swe));
          if (e.sw) begin
            chk("sram_addr", 256'(saddr[1]), 256'(e.saddr));
            chk("sram_wdata", 256'(swd[1]), 256'(e.swd));
            chk("sram_be", 256'(sbe[1]), 256'(e.sbe));
          end
        end
      end
    end
  end

  initial begin : driver
    idle();
    tag_i = '0; rdata_i = '0;
    for (int p = 0; p < NP; p++) begin
      addr_i[p]  = AW'($urandom);
      wdata_i[p] = {TW'(44'hABC), 64'($urandom), 64'($urandom), 2'b11};
      be_i[p]    = BW'($urandom);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1; tick(); tick();
    idle();
    req_i[1] = 8'h01; req_i[3] = 8'h04; tick();
    idle(); tick();
    rst_i = 1'b1; tick();
    idle();
    req_i = {4{8'h10}};
    repeat (5) tick();
    idle();
    req_i[2] = 8'h02; lock_i[2] = 1'b1; tick();
    req_i[0] = 8'h01; tick(); tick();
    req_i[2] = '0; lock_i[2] = 1'b0; tick();
    idle();
    tag_i[0] = 44'hABC;
    req_i[0] = 8'h20; tick();
    idle();
    for (int w = 0; w < NW; w++) rdata_i[w] = line(44'h123, w == 5 || w == 1);
    rdata_i[5] = line(44'hABC, 1);
    req_i[0] = 8'h22; tick();
    idle();
    rdata_i[1] = line(44'hABC, 1);
    tick();
    req_i[0] = 8'h08; we_i[0] = 1'b1; tick();
    we_i[0] = 1'b0; tick();
    idle();
    for (int w = 0; w < NW; w++) rdata_i[w] = line(44'h123, 0);
    rdata_i[3] = line(44'hABC, 1);
    tick();
    req_i[2] = 8'h01; tick();
    idle(); rst_i = 1'b1; tick();
    idle(); req_i[1] = 8'h01; tick();
    repeat (1500) begin
      rst_i = $urandom_range(0, 99) == 0;
      for (int p = 0; p < NP; p++) begin
        req_i[p]   = $urandom_range(0, 9) < 6 ? NW'($urandom_range(1, 255)) : '0;
        lock_i[p]  = $urandom_range(0, 3) == 0;
        we_i[p]    = $urandom_range(0, 9) < 3;
        addr_i[p]  = AW'($urandom);
        tag_i[p]   = $urandom_range(0, 1) != 0 ? 44'hABC : 44'h123;
        wdata_i[p] = {TW'($urandom), 64'($urandom), 64'($urandom), 2'($urandom)};
        be_i[p]    = BW'($urandom);
      end
      for (int w = 0; w < NW; w++)
        rdata_i[w] = line($urandom_range(0, 1) != 0 ? 44'hABC : 44'h123, $urandom_range(0, 2) != 0);
      tick();
    end
    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
